// File: rtl/crcgen_dat32.sv
// CRC-32 FCS generator/inserter for a 32-bit Avalon-ST stream.
// Forwards each packet one clock late and appends the 4-byte FCS after the last payload byte.
//
// state   | meaning
// IDLE    | waiting for sop; beats without sop are dropped
// PAYLOAD | forwarding payload beats, CRC accumulating
// APPEND  | input held off for one beat while the FCS tail is loaded

module crcgen_dat32 #(
  parameter int         DATA_WIDTH   = 32,
  parameter int         EMPTY_WIDTH  = 2,
  parameter bit         REVERSE_DATA = 1'b1,
  parameter logic [7:0] PAD_BYTE     = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [EMPTY_WIDTH-1:0] out_empty
);

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  PAYLOAD  = 2'd1;
  localparam logic [1:0]  APPEND   = 2'd2;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    if (REVERSE_DATA) begin
      r = r ^ {24'h0, b};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end else begin
      r = r ^ {b, 24'h0};
      for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    end
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] tail_q, tail_d;
  logic [1:0]  tail_empty_q, tail_empty_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic [1:0]  out_empty_q, out_empty_d;
  logic        rdy_en_q;

  logic        out_free, accept;
  logic [2:0]  n_bytes;
  logic [3:0]  nb4, pos;
  logic [31:0] crc_base, crc_upd, fcs, eop_beat, tail_beat;
  logic [7:0]  in_b [4];
  logic [7:0]  fcs_b [4];
  logic [7:0]  seq_b [8];

  assign out_free = !out_valid_q | out_ready;
  assign in_ready = rdy_en_q & out_free & (state_q != APPEND);
  assign accept   = in_valid & in_ready;

  // The eop beat and the tail are the two halves of one 8-byte window:
  // valid payload bytes, then FCS bytes 0..3, then padding.
  always_comb begin
    n_bytes  = in_eop ? (3'd4 - {1'b0, in_empty}) : 3'd4;
    nb4      = {1'b0, n_bytes};
    pos      = 4'd0;
    crc_base = (state_q == IDLE || in_sop) ? CRC_INIT : crc_q;
    crc_upd  = crc_base;
    for (int i = 0; i < 4; i++) in_b[i] = in_data[31-8*i -: 8];
    for (int i = 0; i < 4; i++) if (3'(i) < n_bytes) crc_upd = crc_byte(crc_upd, in_b[i]);
    fcs = ~crc_upd;
    for (int k = 0; k < 4; k++) fcs_b[k] = REVERSE_DATA ? fcs[8*k +: 8] : fcs[31-8*k -: 8];
    for (int i = 0; i < 8; i++) begin
      pos = 4'(i);
      if (pos < nb4)              seq_b[i] = in_b[2'(i)];
      else if (pos < nb4 + 4'd4)  seq_b[i] = fcs_b[2'(pos - nb4)];
      else                        seq_b[i] = PAD_BYTE;
    end
    eop_beat  = {seq_b[0], seq_b[1], seq_b[2], seq_b[3]};
    tail_beat = {seq_b[4], seq_b[5], seq_b[6], seq_b[7]};
  end

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    tail_d       = tail_q;
    tail_empty_d = tail_empty_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_empty_d  = out_empty_q;
    if (out_free) out_valid_d = 1'b0;
    case (state_q)
      IDLE, PAYLOAD: begin
        if (accept && (state_q == PAYLOAD || in_sop)) begin
          out_valid_d = 1'b1;
          out_sop_d   = in_sop;
          out_eop_d   = 1'b0;
          out_empty_d = 2'd0;
          out_data_d  = in_eop ? eop_beat : in_data;
          if (in_eop) begin
            tail_d       = tail_beat;
            tail_empty_d = in_empty;
            crc_d        = CRC_INIT;
            state_d      = APPEND;
          end else begin
            crc_d   = crc_upd;
            state_d = PAYLOAD;
          end
        end
      end
      APPEND: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b1;
          out_empty_d = tail_empty_q;
          out_data_d  = tail_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      crc_q        <= CRC_INIT;
      tail_q       <= 32'h0;
      tail_empty_q <= 2'd0;
      out_data_q   <= 32'h0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= 2'd0;
      rdy_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      tail_q       <= tail_d;
      tail_empty_q <= tail_empty_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      rdy_en_q     <= 1'b1;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;

endmodule

// File: tb/tb_crcgen_dat32.sv
// Bench for crcgen_dat32: packet-level model of payload + FCS, a receive-side residue
// check on the output stream, and literal expectations for the "123456789" packet.
module tb_crcgen_dat32;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid, in_ready, in_sop, in_eop;
  logic [1:0]  in_empty;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_sop, out_eop;
  logic [1:0]  out_empty;

  int checks = 0, errors = 0;
  beat_t exp_q[$];
  beat_t cap_q[$];
  bq_t   pkt, rx;
  logic  in_pkt = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  int    ov_cnt = 0, bub_cnt = 0, eop_cnt = 0, stall_cnt = 0;
  logic  bub_en = 1'b0;
  logic  stall_mode = 1'b0;
  logic [3:0] pat = 4'b1001;
  int    cyc = 0;

  crcgen_dat32 dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty)
  );

  always #5 clk = ~clk;

  // Bit-serial MSB-first register fed with LSB-first bits, reflected at the end.
  function automatic logic [31:0] crc32_ref(input bq_t b);
    logic [31:0] c, r;
    logic fb;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[31] ^ b[i][k];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C1_1DB7;
      end
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    out_ready = stall_mode ? pat[cyc % 4] : 1'b1;
  end

  always @(negedge clk) begin
    beat_t cur, e;
    bq_t   wire_b;
    logic [31:0] fcs;
    int n;
    cur = {out_data, out_sop, out_eop, out_empty};
    if (!reset_n) begin
      exp_q.delete(); pkt.delete(); rx.delete();
      in_pkt = 1'b0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_data", out_data, prev_beat.d);
        chk("stall_ctl", 32'({out_valid, out_sop, out_eop, out_empty}),
            32'({1'b1, prev_beat.sop, prev_beat.eop, prev_beat.emp}));
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        stall_cnt++;
      end
      if (out_valid && out_ready) begin
        cap_q.push_back(cur);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %h with no beat expected", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_ctl", 32'({out_sop, out_eop, out_empty}), 32'({e.sop, e.eop, e.emp}));
        end
        if (out_sop) rx.delete();
        n = out_eop ? 4 - int'(out_empty) : 4;
        for (int b = 0; b < n; b++) rx.push_back(out_data[31-8*b -: 8]);
        if (out_eop) begin
          chk("rx_residue", crc32_ref(rx), 32'h2144_DF1C);
          rx.delete();
          eop_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = cur;
      if (out_valid) ov_cnt++;
      if (bub_en && !in_ready) bub_cnt++;
      if (in_valid && in_ready && (in_pkt || in_sop)) begin
        if (in_sop) pkt.delete();
        in_pkt = 1'b1;
        if (!in_eop) begin
          for (int b = 0; b < 4; b++) pkt.push_back(in_data[31-8*b -: 8]);
          exp_q.push_back({in_data, in_sop, 1'b0, 2'b00});
        end else begin
          n = 4 - int'(in_empty);
          wire_b.delete();
          for (int b = 0; b < n; b++) begin
            pkt.push_back(in_data[31-8*b -: 8]);
            wire_b.push_back(in_data[31-8*b -: 8]);
          end
          fcs = crc32_ref(pkt);
          for (int k = 0; k < 4; k++) wire_b.push_back(fcs[8*k +: 8]);
          while (wire_b.size() < 8) wire_b.push_back(8'h00);
          exp_q.push_back({wire_b[0], wire_b[1], wire_b[2], wire_b[3], in_sop, 1'b0, 2'b00});
          exp_q.push_back({wire_b[4], wire_b[5], wire_b[6], wire_b[7], 1'b0, 1'b1, in_empty});
          in_pkt = 1'b0;
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
    int n;
    n = 0;
    in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stuck low for data %h", d);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_t1();
    send_beat(32'h3132_3334, 1'b1, 1'b0, 2'd0);
    send_beat(32'h3536_3738, 1'b0, 1'b0, 2'd0);
    send_beat(32'h39AA_BBCC, 1'b0, 1'b1, 2'd3);
  endtask

  task automatic check_t1(input string tag);
    beat_t exp_b [4];
    beat_t got;
    exp_b[0] = {32'h3132_3334, 1'b1, 1'b0, 2'd0};
    exp_b[1] = {32'h3536_3738, 1'b0, 1'b0, 2'd0};
    exp_b[2] = {32'h3926_39F4, 1'b0, 1'b0, 2'd0};
    exp_b[3] = {32'hCB00_0000, 1'b0, 1'b1, 2'd3};
    chk({tag, "_beat_count"}, 32'(cap_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      chk({tag, "_literal_data"}, got.d, exp_b[i].d);
      chk({tag, "_literal_ctl"}, 32'({got.sop, got.eop, got.emp}),
          32'({exp_b[i].sop, exp_b[i].eop, exp_b[i].emp}));
    end
  endtask

  initial begin
    bq_t nine;
    int  e0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_sop = 1'b0; in_eop = 1'b0;
    in_empty = 2'd0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ctl", 32'({out_sop, out_eop, out_empty}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    #1 chk("rel_in_ready_before_clk", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_after_clk", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) nine.push_back(8'h31 + 8'(i));
    chk("model_crc_123456789", crc32_ref(nine), 32'hCBF4_3926);

    // 1: reference packet, no backpressure
    cap_q.delete();
    send_t1();
    wait_drain();
    check_t1("t1");

    // 2: same packet under 1,0,0,1 out_ready pattern
    cap_q.delete(); stall_cnt = 0;
    stall_mode = 1'b1;
    send_t1();
    wait_drain();
    stall_mode = 1'b0;
    @(posedge clk); #1;
    check_t1("t2");
    chk("t2_stalls_seen", 32'(stall_cnt > 0), 32'd1);

    // 3: four back-to-back 64-byte packets, one in_ready bubble each
    e0 = eop_cnt; bub_cnt = 0; bub_en = 1'b1;
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 16; j++)
        send_beat({8'(p*37 + 4*j), 8'(p*37 + 4*j + 1), 8'(p*37 + 4*j + 2), 8'(p*37 + 4*j + 3)},
                  j == 0, j == 15, 2'd0);
    wait_drain();
    bub_en = 1'b0;
    chk("t3_bubbles", 32'(bub_cnt), 32'd4);
    chk("t3_eops", 32'(eop_cnt - e0), 32'd4);

    // 4: single-beat packet with empty=2
    cap_q.delete();
    send_beat(32'hAB01_5A5A, 1'b1, 1'b1, 2'd2);
    wait_drain();
    chk("t4_beat_count", 32'(cap_q.size()), 32'd2);
    chk("t4_payload", 32'(cap_q.size() > 0 ? cap_q[0].d[31:16] : 16'h0), 32'h0000_AB01);

    // 5: non-sop beats in IDLE are dropped; sop mid-packet restarts
    ov_cnt = 0;
    send_beat(32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0);
    send_beat(32'h0102_0304, 1'b0, 1'b1, 2'd1);
    repeat (3) @(posedge clk); #1;
    chk("t5_no_out_idle", 32'(ov_cnt), 32'd0);
    e0 = eop_cnt;
    send_beat(32'h1111_1111, 1'b1, 1'b0, 2'd0);
    send_beat(32'h2222_2222, 1'b0, 1'b0, 2'd0);
    send_beat(32'h3333_3333, 1'b1, 1'b0, 2'd0);
    send_beat(32'h4444_4444, 1'b0, 1'b1, 2'd1);
    wait_drain();
    chk("t5_eops", 32'(eop_cnt - e0), 32'd1);

    // 6: reset during APPEND, then a clean packet
    send_beat(32'h5555_5555, 1'b1, 1'b0, 2'd0);
    send_beat(32'h6666_6666, 1'b0, 1'b1, 2'd0);
    reset_n = 1'b0;
    #1;
    chk("t6_out_valid_cleared", 32'(out_valid), 32'd0);
    chk("t6_in_ready_in_reset", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    e0 = eop_cnt; cap_q.delete();
    send_beat(32'hC0FF_EE00, 1'b1, 1'b0, 2'd0);
    send_beat(32'h1234_5678, 1'b0, 1'b1, 2'd0);
    wait_drain();
    chk("t6_eops", 32'(eop_cnt - e0), 32'd1);
    chk("t6_beat_count", 32'(cap_q.size()), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
